traffic_light_monitor: RTL and testbench
========================================

// Module: traffic_light_monitor
// PURPOSE
//  Passive checker on the red/amber/green outputs of the traffic light controller.
//  Decodes the light pattern each cycle and checks it against the legal sequence.
//  Flags illegal patterns, skipped or backward steps, and stuck phases, and counts
//  completed light cycles.
//  Used in the bench and on-chip as a safety monitor beside the controller.
// PARAMETERS
//  MAX_DWELL  16  max consecutive samples in one phase; MAX_DWELL+1 samples = timeout
//  MIN_DWELL   2  min samples before leaving a phase (only with TLM_MIN_DWELL_EN)
//  CNT_W       8  width of completed-cycle counter
// PORTS
//  clk       in   1      system clock, rising edge
//  rst       in   1      asynchronous, active-high reset
//  red       in   1      red lamp from controller
//  amber     in   1      amber lamp from controller
//  green     in   1      green lamp from controller
//  clr_err   in   1      synchronous clear of sticky err/err_code
//  phase     out  3      last sampled legal pattern {red,amber,green}; 000 when unsynced
//  valid     out  1      1 = monitor synchronised to a legal sequence
//  err       out  1      sticky error flag
//  err_code  out  2      first error since clear: 01 illegal pattern, 10 bad transition, 11 dwell
//  cycles    out  CNT_W  completed AMBER->RED transitions, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - Reset (async, rst=1): phase=000, valid=0, err=0, err_code=00, cycles=0, dwell=0, state UNSYNC.
//  - Inputs are sampled on each rising clk. All outputs are registered and reflect the sample one edge later.
//  - Legal patterns: RED=100, RED_AMBER=110, GREEN=001, AMBER=010.
//  - Legal successors: RED->RED_AMBER->GREEN->AMBER->RED. Holding the same pattern is always legal.
//  - Illegal patterns: 000, 011, 101, 111.
//  - States:
//    - UNSYNC: on a legal sample go to SYNC (valid=1, phase=sample, dwell=1). On an illegal sample stay, with no error raised.
//    - SYNC, sample==phase: dwell++ (saturating). If dwell==MAX_DWELL before the increment, raise a dwell error.
//    - SYNC, sample is the legal successor: phase=sample, dwell=1. If it was AMBER->RED, cycles++.
//    - SYNC, illegal pattern: raise code 01.
//    - SYNC, any other legal pattern: raise code 10.
//  - Error raise:
//    - err=1. err_code is loaded only if err was 0 (first error wins).
//    - Go to UNSYNC: valid=0, phase=000, dwell=0. cycles is not incremented on the error edge.
//    - Priority when several errors fire on one edge: 01 > 10 > 11.
//  - clr_err=1: err=0, err_code=00 on the next edge. If an error is raised on the same edge, the new error wins (err=1, code=new).
//  - Resync after an error follows the UNSYNC rule; it does not clear err.
//  - dwell width is clog2(MAX_DWELL+1); it saturates, never wraps. cycles wraps 2^CNT_W-1 -> 0 silently.
//  - Reset mid-sequence returns everything to reset values immediately, independent of clk.
// CONFIGURATION
//  TLM_MIN_DWELL_EN defined: on a legal successor step, if the old dwell < MIN_DWELL, raise code 11 (no cycles++).
//  TLM_MIN_DWELL_EN undefined: no minimum check; MIN_DWELL is unused; exit after a 1-sample phase is legal.
// TESTING
//  1. rst, then 100,110,001,010 x3 samples each, then 100 -> valid=1 from 2nd edge, err=0, cycles=1, phase tracks each pattern.
//  2. synced in 110, drive 111 -> next edge err=1, err_code=01, valid=0, phase=000; then 100 -> valid=1, err stays 1.
//  3. synced in 100, drive 001 (skip) -> err_code=10. Then illegal 000 after clr_err -> err_code=01. Second error without clear keeps the first code.
//  4. MAX_DWELL=16, hold 001 for 17 samples -> err=1, err_code=11 on 17th edge; 16 samples then 010 -> no error.
//  5. clr_err pulse with no error -> err=0; clr_err on same edge as illegal 101 -> err=1, err_code=01.
//  6. rst asserted mid-GREEN between edges -> outputs zero at once; with TLM_MIN_DWELL_EN and MIN_DWELL=2, 100 for 1 sample then 110 -> err_code=11.
//  7. Run 256 full sequences with CNT_W=8 -> cycles wraps to 0, err=0.

Source files
------------

// File: rtl/traffic_light_monitor_if.sv
// Lamp inputs, error-clear strobe and monitor status outputs of traffic_light_monitor.
// master = controller/bench side, slave = monitor side.
interface traffic_light_monitor_if #(
    parameter int CNT_W = 8
);
    logic             red;
    logic             amber;
    logic             green;
    logic             clr_err;
    logic [2:0]       phase;
    logic             valid;
    logic             err;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] cycles;

    modport master (
        output red, amber, green, clr_err,
        input  phase, valid, err, err_code, cycles
    );

    modport slave (
        input  red, amber, green, clr_err,
        output phase, valid, err, err_code, cycles
    );
endinterface

// File: rtl/traffic_light_monitor.sv
// Passive safety monitor for red/amber/green lamp outputs: sequence, dwell and cycle tracking.
// Optional minimum-dwell check enabled by defining TLM_MIN_DWELL_EN.
//
// state     | meaning
// ST_UNSYNC | waiting for a legal pattern to lock on; phase=000, valid=0
// ST_SYNC   | locked to the legal sequence; phase holds last legal pattern
module traffic_light_monitor #(
    parameter int MAX_DWELL = 16,
    parameter int MIN_DWELL = 2,
    parameter int CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    traffic_light_monitor_if.slave mon
);
    localparam int DW = $clog2(MAX_DWELL + 1);
    localparam logic [DW-1:0] MaxDw = DW'(MAX_DWELL);
    localparam logic [DW-1:0] MinDw = DW'(MIN_DWELL);
    localparam logic [DW-1:0] OneDw = DW'(1);
`ifdef TLM_MIN_DWELL_EN
    localparam bit MinChkEn = 1'b1;
`else
    localparam bit MinChkEn = 1'b0;
`endif

    localparam logic [2:0] PatRed      = 3'b100;
    localparam logic [2:0] PatRedAmber = 3'b110;
    localparam logic [2:0] PatGreen    = 3'b001;
    localparam logic [2:0] PatAmber    = 3'b010;

    localparam logic [1:0] ErrNone    = 2'b00;
    localparam logic [1:0] ErrIllegal = 2'b01;
    localparam logic [1:0] ErrStep    = 2'b10;
    localparam logic [1:0] ErrDwell   = 2'b11;

    typedef enum logic {ST_UNSYNC, ST_SYNC} state_e;

    state_e           state_q, state_d;
    logic [2:0]       phase_q, phase_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;

    logic [2:0] sample;
    logic       legal;
    logic [2:0] succ;
    logic [1:0] raise;

    assign sample = {mon.red, mon.amber, mon.green};
    assign legal  = (sample == PatRed) || (sample == PatRedAmber) ||
                    (sample == PatGreen) || (sample == PatAmber);

    always_comb begin
        case (phase_q)
            PatRed:      succ = PatRedAmber;
            PatRedAmber: succ = PatGreen;
            PatGreen:    succ = PatAmber;
            default:     succ = PatRed;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_UNSYNC;
            phase_q    <= '0;
            dwell_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= ErrNone;
            cycles_q   <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            dwell_q    <= dwell_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            cycles_q   <= cycles_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        dwell_d    = dwell_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        cycles_d   = cycles_q;
        raise      = ErrNone;

        if (state_q == ST_UNSYNC) begin
            if (legal) begin
                state_d = ST_SYNC;
                phase_d = sample;
                dwell_d = OneDw;
            end
        end else begin
            if (!legal) begin
                raise = ErrIllegal;
            end else if (sample == phase_q) begin
                // Timeout fires before the counter could pass MAX_DWELL, so it never wraps.
                if (dwell_q == MaxDw) raise = ErrDwell;
                else                  dwell_d = dwell_q + OneDw;
            end else if (sample == succ) begin
                if (MinChkEn && (dwell_q < MinDw)) begin
                    raise = ErrDwell;
                end else begin
                    phase_d = sample;
                    dwell_d = OneDw;
                    if (phase_q == PatAmber) cycles_d = cycles_q + CNT_W'(1);
                end
            end else begin
                raise = ErrStep;
            end
        end

        // A new error beats a simultaneous clear, and then owns the code.
        if (raise != ErrNone) begin
            state_d  = ST_UNSYNC;
            phase_d  = '0;
            dwell_d  = '0;
            cycles_d = cycles_q;
            err_d    = 1'b1;
            if (!err_q || mon.clr_err) err_code_d = raise;
        end else if (mon.clr_err) begin
            err_d      = 1'b0;
            err_code_d = ErrNone;
        end
    end

    always_comb begin
        mon.phase    = phase_q;
        mon.valid    = (state_q == ST_SYNC);
        mon.err      = err_q;
        mon.err_code = err_code_q;
        mon.cycles   = cycles_q;
    end
endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: vector table, corner sequences, random vs model.
module tb_traffic_light_monitor;
    localparam int MAX_DWELL = 16;
    localparam int MIN_DWELL = 2;
    localparam int CNT_W     = 8;
`ifdef TLM_MIN_DWELL_EN
    localparam bit MIN_EN = 1'b1;
`else
    localparam bit MIN_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    traffic_light_monitor_if #(.CNT_W(CNT_W)) tif ();

    traffic_light_monitor #(
        .MAX_DWELL(MAX_DWELL),
        .MIN_DWELL(MIN_DWELL),
        .CNT_W    (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mon(tif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] seq [4];

    // Reference: position in the four-step ring plus counters.
    bit m_sync;
    int m_idx;
    int m_dwell;
    bit m_err;
    int m_code;
    int m_cycles;

    typedef struct {
        logic [2:0] pat;
        bit         clr;
        logic [2:0] ph;
        bit         v;
        bit         e;
        logic [1:0] code;
        logic [7:0] cyc;
    } vec_t;

    vec_t vt [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [2:0] p);
        for (int i = 0; i < 4; i++) if (seq[i] == p) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_sync = 0; m_idx = 0; m_dwell = 0; m_err = 0; m_code = 0; m_cycles = 0;
    endtask

    task automatic model_step(input logic [2:0] pat, input bit clr);
        int i;
        int code;
        i = idx_of(pat);
        code = 0;
        if (!m_sync) begin
            if (i >= 0) begin m_sync = 1; m_idx = i; m_dwell = 1; end
        end else if (i < 0) begin
            code = 1;
        end else if (i == m_idx) begin
            if (m_dwell == MAX_DWELL) code = 3;
            else m_dwell++;
        end else if (i == (m_idx + 1) % 4) begin
            if (MIN_EN && m_dwell < MIN_DWELL) code = 3;
            else begin
                if (m_idx == 3) m_cycles = (m_cycles + 1) % (1 << CNT_W);
                m_idx = i;
                m_dwell = 1;
            end
        end else begin
            code = 2;
        end
        if (code != 0) begin
            if (!m_err || clr) m_code = code;
            m_err = 1; m_sync = 0; m_dwell = 0;
        end else if (clr) begin
            m_err = 0; m_code = 0;
        end
    endtask

    task automatic tick(input logic [2:0] pat, input bit clr);
        {tif.red, tif.amber, tif.green} = pat;
        tif.clr_err = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".phase"}, 32'(tif.phase), m_sync ? 32'(seq[m_idx]) : 32'd0);
        chk({tag, ".valid"}, 32'(tif.valid), 32'(m_sync));
        chk({tag, ".err"}, 32'(tif.err), 32'(m_err));
        chk({tag, ".err_code"}, 32'(tif.err_code), 32'(m_code));
        chk({tag, ".cycles"}, 32'(tif.cycles), 32'(m_cycles));
    endtask

    task automatic step(input logic [2:0] pat, input bit clr, input string tag);
        tick(pat, clr);
        model_step(pat, clr);
        check_model(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        seq[0] = 3'b100; seq[1] = 3'b110; seq[2] = 3'b001; seq[3] = 3'b010;
        rst = 1'b1;
        tif.red = 1'b0; tif.amber = 1'b0; tif.green = 1'b0; tif.clr_err = 1'b0;

        vt[0]  = '{3'b100, 1'b0, 3'b100, 1'b1, 1'b0, 2'b00, 8'd0};
        vt[1]  = '{3'b100, 1'b0, 3'b100, 1'b1, 1'b0, 2'b00, 8'd0};
        vt[2]  = '{3'b110, 1'b0, 3'b110, 1'b1, 1'b0, 2'b00, 8'd0};
        vt[3]  = '{3'b001, 1'b0, 3'b001, 1'b1, 1'b0, 2'b00, 8'd0};
        vt[4]  = '{3'b010, 1'b0, 3'b010, 1'b1, 1'b0, 2'b00, 8'd0};
        vt[5]  = '{3'b100, 1'b0, 3'b100, 1'b1, 1'b0, 2'b00, 8'd1};
        vt[6]  = '{3'b110, 1'b0, 3'b110, 1'b1, 1'b0, 2'b00, 8'd1};
        vt[7]  = '{3'b111, 1'b0, 3'b000, 1'b0, 1'b1, 2'b01, 8'd1};
        vt[8]  = '{3'b100, 1'b0, 3'b100, 1'b1, 1'b1, 2'b01, 8'd1};
        vt[9]  = '{3'b001, 1'b0, 3'b000, 1'b0, 1'b1, 2'b01, 8'd1};
        vt[10] = '{3'b100, 1'b1, 3'b100, 1'b1, 1'b0, 2'b00, 8'd1};
        vt[11] = '{3'b001, 1'b0, 3'b000, 1'b0, 1'b1, 2'b10, 8'd1};
        vt[12] = '{3'b100, 1'b1, 3'b100, 1'b1, 1'b0, 2'b00, 8'd1};
        vt[13] = '{3'b000, 1'b0, 3'b000, 1'b0, 1'b1, 2'b01, 8'd1};
        vt[14] = '{3'b101, 1'b0, 3'b000, 1'b0, 1'b1, 2'b01, 8'd1};
        vt[15] = '{3'b010, 1'b1, 3'b010, 1'b1, 1'b0, 2'b00, 8'd1};
        vt[16] = '{3'b101, 1'b1, 3'b000, 1'b0, 1'b1, 2'b01, 8'd1};
        vt[17] = '{3'b110, 1'b0, 3'b110, 1'b1, 1'b1, 2'b01, 8'd1};
        vt[18] = '{3'b001, 1'b0, 3'b001, 1'b1, 1'b1, 2'b01, 8'd1};
        vt[19] = '{3'b001, 1'b1, 3'b001, 1'b1, 1'b0, 2'b00, 8'd1};
        vt[20] = '{3'b001, 1'b1, 3'b001, 1'b1, 1'b0, 2'b00, 8'd1};

        // Reset state
        do_reset();
        chk("rst.phase", 32'(tif.phase), 32'd0);
        chk("rst.valid", 32'(tif.valid), 32'd0);
        chk("rst.err", 32'(tif.err), 32'd0);
        chk("rst.err_code", 32'(tif.err_code), 32'd0);
        chk("rst.cycles", 32'(tif.cycles), 32'd0);

        // Vector table; one-sample phases are only legal without the minimum-dwell check
        if (!MIN_EN) begin
            for (int i = 0; i < 21; i++) begin
                tick(vt[i].pat, vt[i].clr);
                chk($sformatf("vec%0d.phase", i), 32'(tif.phase), 32'(vt[i].ph));
                chk($sformatf("vec%0d.valid", i), 32'(tif.valid), 32'(vt[i].v));
                chk($sformatf("vec%0d.err", i), 32'(tif.err), 32'(vt[i].e));
                chk($sformatf("vec%0d.code", i), 32'(tif.err_code), 32'(vt[i].code));
                chk($sformatf("vec%0d.cycles", i), 32'(tif.cycles), 32'(vt[i].cyc));
            end
        end

        // Dwell timeout on the 17th identical sample
        do_reset();
        for (int i = 0; i < 16; i++) step(3'b001, 1'b0, "dwell16");
        chk("dwell16.err", 32'(tif.err), 32'd0);
        step(3'b001, 1'b0, "dwell17");
        chk("dwell17.err", 32'(tif.err), 32'd1);
        chk("dwell17.code", 32'(tif.err_code), 32'd3);
        chk("dwell17.valid", 32'(tif.valid), 32'd0);

        do_reset();
        for (int i = 0; i < 16; i++) step(3'b001, 1'b0, "dwell_ok");
        step(3'b010, 1'b0, "dwell_exit");
        chk("dwell_exit.err", 32'(tif.err), 32'd0);
        chk("dwell_exit.phase", 32'(tif.phase), 32'h2);

        // Clear with no pending error
        step(3'b010, 1'b1, "clr_idle");
        chk("clr_idle.err", 32'(tif.err), 32'd0);

        // One-sample RED then RED_AMBER
        do_reset();
        step(3'b100, 1'b0, "min1");
        step(3'b110, 1'b0, "min2");
        chk("min2.err", 32'(tif.err), MIN_EN ? 32'd1 : 32'd0);
        chk("min2.code", 32'(tif.err_code), MIN_EN ? 32'd3 : 32'd0);

        // Async reset between edges while in GREEN
        do_reset();
        for (int p = 0; p < 3; p++) begin
            step(seq[p], 1'b0, "pre_rst");
            step(seq[p], 1'b0, "pre_rst");
        end
        chk("pre_rst.phase", 32'(tif.phase), 32'h1);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst.phase", 32'(tif.phase), 32'd0);
        chk("async_rst.valid", 32'(tif.valid), 32'd0);
        chk("async_rst.cycles", 32'(tif.cycles), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // 256 full sequences: counter wraps to zero
        for (int k = 0; k < 256; k++)
            for (int p = 0; p < 4; p++) begin
                step(seq[p], 1'b0, "wrap");
                step(seq[p], 1'b0, "wrap");
            end
        chk("wrap.cycles255", 32'(tif.cycles), 32'd255);
        step(3'b100, 1'b0, "wrap_last");
        chk("wrap.cycles0", 32'(tif.cycles), 32'd0);
        chk("wrap.err", 32'(tif.err), 32'd0);

        // Random biased stimulus against the reference model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [2:0] cur;
            logic [2:0] pat;
            bit clr;
            r = int'($urandom_range(0, 99));
            cur = m_sync ? seq[m_idx] : seq[$urandom_range(0, 3)];
            if (r < 45)      pat = cur;
            else if (r < 75) pat = m_sync ? seq[(m_idx + 1) % 4] : cur;
            else if (r < 88) pat = seq[$urandom_range(0, 3)];
            else             pat = 3'($urandom_range(0, 7));
            clr = ($urandom_range(0, 19) == 0);
            step(pat, clr, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
